debounce_array: RTL and testbench



---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 119 +++++++++++
 rtl/synchroniser.sv | 24 ++
 rtl/debounce_array.sv | 35 +++
 tb/tb_debounce_array.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debounce_array block and its channels.
package debounce_pkg;

    localparam int DEFAULT_DELAY_COUNTS = 2500;
    localparam int DEFAULT_HOLD_COUNTS  = 0;

    // Bits needed to hold 0..max_count, never less than one so a disabled counter still elaborates.
    function automatic int counter_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, optional inversion, stability counter, level and event pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS,
    parameter int HOLD_COUNTS  = DEFAULT_HOLD_COUNTS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_pressed,
    output logic press,
    output logic released,
    output logic long_press
);

    localparam int            CW        = counter_width(DELAY_COUNTS);
    localparam logic [CW-1:0] DELAY_MAX = CW'(DELAY_COUNTS);

    logic button_sync;
    logic s;

    synchroniser #(.STAGES(2)) u_sync (
        .clk (clk),
        .d   (button_raw),
        .q   (button_sync)
    );

    assign s = button_sync ^ ACTIVE_LOW;

    logic          prev_q, prev_d;
    logic [CW-1:0] count_q, count_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          settled;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        prev_d    = prev_q;
        count_d   = count_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        settled   = (s == prev_q) && (count_q == DELAY_MAX);

        if (s != prev_q) begin
            prev_d  = s;
            count_d = '0;
        end else if (!settled) begin
            count_d = count_q + CW'(1);
        end

        if (settled && (prev_q != level_q)) begin
            level_d   = prev_q;
            press_d   = prev_q;
            release_d = !prev_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= 1'b0;
            count_q   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            count_q   <= count_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign button_pressed = level_q;
    assign press          = press_q;
    assign released       = release_q;

    generate
        if (HOLD_COUNTS == 0) begin : g_no_hold
            assign long_press = 1'b0;
        end else begin : g_hold
            localparam int            HW       = counter_width(HOLD_COUNTS);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_COUNTS);

            logic [HW-1:0] hold_q, hold_d;
            logic          long_q, long_d;

            // Saturation at HOLD_MAX is what limits long_press to one pulse per press.
            always_comb begin
                hold_d = hold_q;
                long_d = 1'b0;
                if (!level_q) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                    long_d = (hold_d == HOLD_MAX);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                end
            end

            assign long_press = long_q;
        end
    endgenerate

endmodule

// File: rtl/synchroniser.sv
// Plain multi-stage flop synchroniser for one asynchronous input bit.
module synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: no reset on these flops; they flush within STAGES cycles and a reset would only add a path into metastability-prone cells.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_array.sv
// N independent debounced button channels with press, release and long-press event pulses.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int N_CHANNELS   = 4,
    parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS,
    parameter int HOLD_COUNTS  = DEFAULT_HOLD_COUNTS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CHANNELS-1:0] button,
    output logic [N_CHANNELS-1:0] button_pressed,
    output logic [N_CHANNELS-1:0] press,
    output logic [N_CHANNELS-1:0] released,
    output logic [N_CHANNELS-1:0] long_press
);

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DELAY_COUNTS (DELAY_COUNTS),
            .HOLD_COUNTS  (HOLD_COUNTS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_channel (
            .clk            (clk),
            .reset          (reset),
            .button_raw     (button[i]),
            .button_pressed (button_pressed[i]),
            .press          (press[i]),
            .released       (released[i]),
            .long_press     (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench: stimulus queues expected pulse cycles, a negedge monitor pops and compares them.
module tb_debounce_array;

    localparam int N   = 4;
    localparam int D   = 8;
    localparam int H   = 20;
    localparam int LAT = D + 3;

    typedef struct {
        int         cycle;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] button = '0;
    logic [N-1:0] al_button = '1;
    logic [N-1:0] lvl, prs, rls, lng;
    logic [N-1:0] al_lvl, al_prs, al_rls, al_lng;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   e0;
    exp_t q_main[$];
    exp_t q_al[$];

    debounce_array #(
        .N_CHANNELS(N), .DELAY_COUNTS(D), .HOLD_COUNTS(H), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .button_pressed(lvl),
        .press(prs), .released(rls), .long_press(lng)
    );

    debounce_array #(
        .N_CHANNELS(N), .DELAY_COUNTS(D), .HOLD_COUNTS(H), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset(reset), .button(al_button), .button_pressed(al_lvl),
        .press(al_prs), .released(al_rls), .long_press(al_lng)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Merge into an existing entry for the same cycle, otherwise insert in cycle order.
    function automatic void add_exp(input bit al, input int cycle,
                                    input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        exp_t tmp[$];
        exp_t e;
        int   idx;
        bit   merged;
        tmp    = al ? q_al : q_main;
        idx    = tmp.size();
        merged = 1'b0;
        for (int i = 0; i < tmp.size(); i++) begin
            if (tmp[i].cycle == cycle) begin
                tmp[i].press |= p;
                tmp[i].rel   |= r;
                tmp[i].lng   |= l;
                merged = 1'b1;
                break;
            end else if (tmp[i].cycle > cycle) begin
                idx = i;
                break;
            end
        end
        if (!merged) begin
            e.cycle = cycle;
            e.press = p;
            e.rel   = r;
            e.lng   = l;
            tmp.insert(idx, e);
        end
        if (al) q_al = tmp;
        else    q_main = tmp;
    endfunction

    task automatic monitor(input string tag, input bit al,
                           input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        exp_t tmp[$];
        exp_t e;
        tmp = al ? q_al : q_main;
        if (|{p, r, l}) begin
            if (tmp.size() == 0) begin
                check({tag, " unexpected pulse"}, {20'd0, p, r, l}, 32'd0);
            end else begin
                e = tmp.pop_front();
                check({tag, " pulse cycle"}, cyc, e.cycle);
                check({tag, " press"}, {28'd0, p}, {28'd0, e.press});
                check({tag, " release"}, {28'd0, r}, {28'd0, e.rel});
                check({tag, " long_press"}, {28'd0, l}, {28'd0, e.lng});
            end
        end else if (tmp.size() > 0 && tmp[0].cycle <= cyc) begin
            e = tmp.pop_front();
            check({tag, " missing pulse"}, 32'd0, {20'd0, e.press, e.rel, e.lng});
        end
        if (al) q_al = tmp;
        else    q_main = tmp;
    endtask

    always @(negedge clk) begin
        monitor("main", 1'b0, prs, rls, lng);
        monitor("al", 1'b1, al_prs, al_rls, al_lng);
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset level", {28'd0, lvl}, 32'd0);
        check("reset pulses", {20'd0, prs, rls, lng}, 32'd0);
        check("reset al level", {28'd0, al_lvl}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press and release on channel 0, released before long-press matures.
        e0 = cyc + 1;
        button[0] = 1'b1;
        add_exp(1'b0, e0 + LAT, 4'b0001, 4'b0000, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("clean press level", {28'd0, lvl}, 32'h1);
        e0 = cyc + 1;
        button[0] = 1'b0;
        add_exp(1'b0, e0 + LAT, 4'b0000, 4'b0001, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("clean release level", {28'd0, lvl}, 32'h0);

        // Bouncing channel 1: 3-cycle toggles never settle.
        for (int k = 0; k < 10; k++) begin
            button[1] = (k % 2 == 0);
            repeat (3) @(negedge clk);
        end
        check("bounce no level", {28'd0, lvl}, 32'h0);
        e0 = cyc + 1;
        button[1] = 1'b1;
        add_exp(1'b0, e0 + LAT, 4'b0010, 4'b0000, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("bounce settled level", {28'd0, lvl}, 32'h2);
        e0 = cyc + 1;
        button[1] = 1'b0;
        add_exp(1'b0, e0 + LAT, 4'b0000, 4'b0010, 4'b0000);
        repeat (LAT + 4) @(negedge clk);

        // Long press on channel 2, then release with no second long-press.
        e0 = cyc + 1;
        button[2] = 1'b1;
        add_exp(1'b0, e0 + LAT, 4'b0100, 4'b0000, 4'b0000);
        add_exp(1'b0, e0 + LAT + H, 4'b0000, 4'b0000, 4'b0100);
        repeat (45) @(negedge clk);
        check("long press level", {28'd0, lvl}, 32'h4);
        e0 = cyc + 1;
        button[2] = 1'b0;
        add_exp(1'b0, e0 + LAT, 4'b0000, 4'b0100, 4'b0000);
        repeat (45) @(negedge clk);
        check("long release level", {28'd0, lvl}, 32'h0);

        // Channels 0 and 3 together; release only channel 0.
        e0 = cyc + 1;
        button[0] = 1'b1;
        button[3] = 1'b1;
        add_exp(1'b0, e0 + LAT, 4'b1001, 4'b0000, 4'b0000);
        add_exp(1'b0, e0 + LAT + H, 4'b0000, 4'b0000, 4'b1001);
        repeat (40) @(negedge clk);
        e0 = cyc + 1;
        button[0] = 1'b0;
        add_exp(1'b0, e0 + LAT, 4'b0000, 4'b0001, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("partial release level", {28'd0, lvl}, 32'h8);

        // Reset while channel 1 is mid-debounce and channel 3 is held.
        e0 = cyc + 1;
        button[1] = 1'b1;
        repeat (8) @(negedge clk);
        check("pre-reset level", {28'd0, lvl}, 32'h8);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset level", {28'd0, lvl}, 32'h0);
        check("mid reset pulses", {20'd0, prs, rls, lng}, 32'h0);
        reset = 1'b0;
        // Synchroniser is already settled, so prev loads on the first post-reset edge.
        e0 = cyc + 1;
        add_exp(1'b0, e0 + D + 1, 4'b1010, 4'b0000, 4'b0000);
        add_exp(1'b0, e0 + D + 1 + H, 4'b0000, 4'b0000, 4'b1010);
        repeat (D + H + 6) @(negedge clk);
        check("post-reset level", {28'd0, lvl}, 32'hA);
        e0 = cyc + 1;
        button[1] = 1'b0;
        button[3] = 1'b0;
        add_exp(1'b0, e0 + LAT, 4'b0000, 4'b1010, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("post-reset release level", {28'd0, lvl}, 32'h0);

        // Active-low instance: raw 0 presses, raw 1 releases.
        e0 = cyc + 1;
        al_button[0] = 1'b0;
        add_exp(1'b1, e0 + LAT, 4'b0001, 4'b0000, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("al press level", {28'd0, al_lvl}, 32'h1);
        e0 = cyc + 1;
        al_button[0] = 1'b1;
        add_exp(1'b1, e0 + LAT, 4'b0000, 4'b0001, 4'b0000);
        repeat (LAT + 4) @(negedge clk);
        check("al release level", {28'd0, al_lvl}, 32'h0);

        repeat (30) @(negedge clk);
        check("main queue drained", q_main.size(), 32'd0);
        check("al queue drained", q_al.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
